cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- System Control Coprocessor register file that responds to writeback-stage requests: mfc0 reads, mtc0 writes, exception commit and eret.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Generates the timer interrupt and the pending-interrupt request that the pipeline samples.
- Instantiated inside the writeback stage; every input is already qualified by the writeback valid bit.

Parameters:
- CNT_DIV, 2: clock cycles per Count increment; must be a power of two, at least 1.
- STATUS_RST, 32'h0040_0000: reset value of Status, with BEV=1 and all other bits 0.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous reset, active low.
- wb_ex  in  1  exception commits this cycle.
- wb_bd  in  1  the excepting instruction sits in a delay slot.
- wb_excode  in  5  exception code.
- wb_pc  in  32  PC of the excepting instruction.
- wb_badvaddr  in  32  faulting address.
- eret_flush  in  1  eret commits this cycle.
- ext_int_in  in  6  hardware interrupt lines, level sensitive.
- cp0_addr  in  8  register select, encoded as {rd[4:0], sel[2:0]}.
- mtc0_we  in  1  write enable.
- cp0_wdata  in  32  write data.
- cp0_rdata  out  32  combinational read data.
- cp0_epc  out  32  EPC register.
- cp0_status  out  32  Status register.
- cp0_cause  out  32  Cause register.
- has_int  out  1  interrupt pending and enabled.

Behaviour:
- Address map (all with sel=0): BadVAddr 0x40, Count 0x48, Compare 0x58, Status 0x60, Cause 0x68, EPC 0x70. Unmapped reads return 0; unmapped writes are ignored.
- Reads are combinational from current register state. A read and a write to the same register in the same cycle returns the old value.
- Reset: every register and output is 0, except Status = STATUS_RST. The tick counter is 0 and has_int is 0.
- Status fields:
  - BEV (bit 22) is constant 1.
  - IM[15:8], EXL (bit 1) and IE (bit 0) are writable by mtc0.
  - All other bits read 0.
- Cause fields:
  - BD (bit 31), TI (bit 30) and ExcCode[6:2] are hardware-written only.
  - IP[9:8] are writable by mtc0.
  - IP[15:10] are loaded every cycle with ext_int_in[5:0]; IP[15] additionally ORs in TI.
  - All other bits read 0.
- Exception commit (wb_ex=1):
  - EXL is set to 1.
  - ExcCode is set to wb_excode.
  - If EXL was 0 beforehand: EPC = wb_bd ? wb_pc-4 : wb_pc, and BD = wb_bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - If wb_excode is 0x04 (AdEL) or 0x05 (AdES): BadVAddr = wb_badvaddr.
- eret_flush=1 clears EXL. If wb_ex and eret_flush are both asserted, wb_ex wins and EXL stays 1.
- mtc0 and exception in the same cycle: the exception updates take priority on shared fields (EXL, EPC). The mtc0 write still applies to all other fields.
- BadVAddr is read-only to mtc0.
- Count timer:
  - A free-running tick counter of width log2(CNT_DIV) wraps every CNT_DIV cycles.
  - Count increments by 1 on the wrap cycle; Count wraps from 0xFFFF_FFFF to 0.
  - An mtc0 write to Count loads cp0_wdata, suppresses that cycle's increment, and leaves the tick counter unchanged.
- Compare / TI:
  - An mtc0 write to Compare loads cp0_wdata and clears TI in the same cycle.
  - TI is set on an increment cycle whose new Count equals Compare.
  - A Compare write in the same cycle as a matching increment: clear wins.
  - TI stays set until the next Compare write. Reset leaves TI=0 even though Count == Compare == 0.
- has_int is registered, driven one cycle after the inputs: has_int = |(Cause[15:8] & Status[15:8]) & IE & ~EXL.
- Reset asserted mid-operation overrides all updates in that cycle.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> cp0_status=0x0040_0000; cp0_cause=0; cp0_epc=0; reads of 0x48 and 0x58 return 0; has_int=0.
- Exception in delay slot: wb_ex=1, wb_bd=1, wb_pc=0xBFC0_0104, excode=0x08 -> EPC=0xBFC0_0100, Cause=0x8000_0020, Status.EXL=1. Then a second wb_ex with pc=0x100 -> EPC unchanged.
- AdEL: wb_ex=1, excode=0x04, badvaddr=0x8000_0003 -> read of 0x40 returns 0x8000_0003. An mtc0 to 0x40 then leaves it unchanged.
- Timer: with CNT_DIV=2, write Count=5, write Compare=7 -> TI=1 exactly 4 cycles later. With Status=0x0040_8001, has_int=1 one cycle after that. A subsequent Compare write clears TI and has_int.
- eret: with EXL=1, pulse eret_flush -> EXL=0. With wb_ex and eret_flush both asserted -> EXL stays 1 and EPC captures wb_pc.
- Software and external interrupts: mtc0 Cause=0x0000_0300 -> reads back 0x300. With ext_int_in=6'b000001, IM=0x04 and IE=1 -> has_int=1. Setting EXL=1 -> has_int=0 on the next cycle.

Source files
------------

// File: rtl/cp0_regfile.sv
// System Control Coprocessor (CP0) register file for the writeback stage.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC, and raises the timer and pending-interrupt request.
module cp0_regfile #(
  parameter int unsigned CNT_DIV    = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        wb_bd,
  input  logic [4:0]  wb_excode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        eret_flush,
  input  logic [5:0]  ext_int_in,
  input  logic [7:0]  cp0_addr,
  input  logic        mtc0_we,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        has_int
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  localparam int unsigned TW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   epc_q, epc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    im_q, im_d;
  logic          exl_q, exl_d;
  logic          ie_q, ie_d;
  logic          bd_q, bd_d;
  logic          ti_q, ti_d;
  logic [1:0]    ip_sw_q, ip_sw_d;
  logic [5:0]    ip_hw_q, ip_hw_d;
  logic [4:0]    excode_q, excode_d;
  logic          has_int_q, has_int_d;

  logic        we_count, we_compare, we_status, we_cause, we_epc;
  logic        wrap, inc;
  logic [31:0] count_inc;
  logic [7:0]  cause_ip;

  assign we_count   = mtc0_we && (cp0_addr == ADDR_COUNT);
  assign we_compare = mtc0_we && (cp0_addr == ADDR_COMPARE);
  assign we_status  = mtc0_we && (cp0_addr == ADDR_STATUS);
  assign we_cause   = mtc0_we && (cp0_addr == ADDR_CAUSE);
  assign we_epc     = mtc0_we && (cp0_addr == ADDR_EPC);

  assign wrap      = (CNT_DIV == 1) || (tick_q == TW'(CNT_DIV - 1));
  assign inc       = wrap && !we_count;
  assign count_inc = count_q + 32'd1;

  // IP[7] is shared between external line 5 and the timer interrupt.
  assign cause_ip   = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign cp0_status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cp0_cause  = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, excode_q, 2'b0};
  assign cp0_epc    = epc_q;
  assign has_int    = has_int_q;

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      ADDR_BADVADDR: cp0_rdata = badvaddr_q;
      ADDR_COUNT:    cp0_rdata = count_q;
      ADDR_COMPARE:  cp0_rdata = compare_q;
      ADDR_STATUS:   cp0_rdata = cp0_status;
      ADDR_CAUSE:    cp0_rdata = cp0_cause;
      ADDR_EPC:      cp0_rdata = epc_q;
      default:       cp0_rdata = 32'h0;
    endcase
  end

  // NOTE: every next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    tick_d     = (CNT_DIV == 1) ? '0 : tick_q + TW'(1);
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = ext_int_in;
    excode_d   = excode_q;

    if (we_count)    count_d = cp0_wdata;
    else if (inc)    count_d = count_inc;

    if (we_compare) begin
      compare_d = cp0_wdata;
      ti_d      = 1'b0;
    end else if (inc && (count_inc == compare_q)) begin
      ti_d = 1'b1;
    end

    if (we_status) begin
      im_d  = cp0_wdata[15:8];
      exl_d = cp0_wdata[1];
      ie_d  = cp0_wdata[0];
    end
    if (we_cause) ip_sw_d = cp0_wdata[9:8];
    if (we_epc)   epc_d   = cp0_wdata;

    // Exception beats eret, which beats an mtc0 write, on the shared fields.
    if (wb_ex) begin
      exl_d    = 1'b1;
      excode_d = wb_excode;
      if (!exl_q) begin
        epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
        bd_d  = wb_bd;
      end
      if (wb_excode == EXC_ADEL || wb_excode == EXC_ADES) badvaddr_d = wb_badvaddr;
    end else if (eret_flush) begin
      exl_d = 1'b0;
    end

    has_int_d = (|(cause_ip & im_q)) && ie_q && !exl_q;
  end

  // NOTE: sequential state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_q <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      epc_q      <= 32'h0;
      tick_q     <= '0;
      im_q       <= STATUS_RST[15:8];
      exl_q      <= STATUS_RST[1];
      ie_q       <= STATUS_RST[0];
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= 2'b0;
      ip_hw_q    <= 6'b0;
      excode_q   <= 5'b0;
      has_int_q  <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      excode_q   <= excode_d;
      has_int_q  <= has_int_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile: reset, exceptions, eret, timer and interrupts.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex, wb_bd, eret_flush, mtc0_we;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, cp0_wdata;
  logic [5:0]  ext_int_in;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic        has_int;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.CNT_DIV(2), .STATUS_RST(32'h0040_0000)) dut (
    .clk(clk), .resetn(resetn),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_excode(wb_excode), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush), .ext_int_in(ext_int_in),
    .cp0_addr(cp0_addr), .mtc0_we(mtc0_we), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .cp0_epc(cp0_epc), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .has_int(has_int)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    cp0_addr  = addr;
    cp0_wdata = data;
    mtc0_we   = 1'b1;
    step();
    mtc0_we   = 1'b0;
  endtask

  task automatic wb_exc(input logic bd, input logic [4:0] code, input logic [31:0] pc,
                        input logic [31:0] bad, input logic eret);
    wb_ex       = 1'b1;
    wb_bd       = bd;
    wb_excode   = code;
    wb_pc       = pc;
    wb_badvaddr = bad;
    eret_flush  = eret;
    step();
    wb_ex       = 1'b0;
    wb_bd       = 1'b0;
    eret_flush  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    logic        found;

    resetn = 1'b0; wb_ex = 1'b0; wb_bd = 1'b0; wb_excode = 5'h0; wb_pc = 32'h0;
    wb_badvaddr = 32'h0; eret_flush = 1'b0; ext_int_in = 6'h0; cp0_addr = 8'h0;
    mtc0_we = 1'b0; cp0_wdata = 32'h0;

    step();
    step();
    check("rst_status", cp0_status, 32'h0040_0000);
    check("rst_cause", cp0_cause, 32'h0);
    check("rst_epc", cp0_epc, 32'h0);
    rd("rst_count", 8'h48, 32'h0);
    rd("rst_compare", 8'h58, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    resetn = 1'b1;

    // Delay-slot exception, then a nested one that must not disturb EPC/BD.
    wb_exc(1'b1, 5'h08, 32'hBFC0_0104, 32'h0, 1'b0);
    check("ds_epc", cp0_epc, 32'hBFC0_0100);
    check("ds_cause", cp0_cause, 32'h8000_0020);
    check("ds_status", cp0_status, 32'h0040_0002);
    wb_exc(1'b0, 5'h08, 32'h0000_0100, 32'h0, 1'b0);
    check("nested_epc", cp0_epc, 32'hBFC0_0100);

    // AdEL captures BadVAddr; mtc0 cannot overwrite it.
    wb_exc(1'b0, 5'h04, 32'h0000_0200, 32'h8000_0003, 1'b0);
    rd("adel_badvaddr", 8'h40, 32'h8000_0003);
    check("adel_cause", cp0_cause, 32'h8000_0010);
    mtc0(8'h40, 32'h1234_5678);
    rd("badvaddr_ro", 8'h40, 32'h8000_0003);
    rd("unmapped_rd", 8'h50, 32'h0);

    // eret clears EXL; simultaneous exception keeps it set and captures EPC.
    eret_flush = 1'b1;
    step();
    eret_flush = 1'b0;
    check("eret_status", cp0_status, 32'h0040_0000);
    wb_exc(1'b0, 5'h08, 32'h0000_2000, 32'h0, 1'b1);
    check("ex_eret_status", cp0_status, 32'h0040_0002);
    check("ex_eret_epc", cp0_epc, 32'h0000_2000);
    check("ex_eret_cause", cp0_cause, 32'h0000_0020);

    // Read while writing the same register returns the old value.
    cp0_addr = 8'h70; cp0_wdata = 32'hABCD_0000; mtc0_we = 1'b1;
    #1;
    check("rdw_old", cp0_rdata, 32'h0000_2000);
    step();
    mtc0_we = 1'b0;
    check("rdw_new", cp0_epc, 32'hABCD_0000);

    // Timer: align Count write to a tick-wrap edge.
    mtc0(8'h60, 32'h0040_8001);
    check("tmr_status", cp0_status, 32'h0040_8001);
    cp0_addr = 8'h48;
    #1;
    prev = cp0_rdata;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (cp0_rdata != prev) found = 1'b1;
      prev = cp0_rdata;
    end
    check("tmr_align", {31'b0, found}, 32'h1);
    step();
    mtc0(8'h48, 32'h0000_0005);
    rd("tmr_count5", 8'h48, 32'h5);
    mtc0(8'h58, 32'h0000_0007);
    rd("tmr_compare", 8'h58, 32'h7);
    step();
    step();
    check("tmr_ti_early", {31'b0, cp0_cause[30]}, 32'h0);
    step();
    check("tmr_ti_set", cp0_cause, 32'h4000_8020);
    rd("tmr_count7", 8'h48, 32'h7);
    check("tmr_hi_lat", {31'b0, has_int}, 32'h0);
    step();
    check("tmr_has_int", {31'b0, has_int}, 32'h1);
    mtc0(8'h58, 32'h0000_1000);
    check("tmr_ti_clr", {31'b0, cp0_cause[30]}, 32'h0);
    step();
    check("tmr_hi_clr", {31'b0, has_int}, 32'h0);

    // Software and external interrupts.
    mtc0(8'h68, 32'h0000_0300);
    rd("sw_ip", 8'h68, 32'h0000_0320);
    ext_int_in = 6'b000001;
    mtc0(8'h60, 32'h0040_0401);
    step();
    check("ext_has_int", {31'b0, has_int}, 32'h1);
    check("ext_cause", cp0_cause, 32'h0000_0720);
    mtc0(8'h60, 32'h0040_0403);
    check("exl_hi_lat", {31'b0, has_int}, 32'h1);
    step();
    check("exl_masks", {31'b0, has_int}, 32'h0);
    ext_int_in = 6'b0;
    mtc0(8'h60, 32'h0040_0101);
    step();
    check("sw_has_int", {31'b0, has_int}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
